// File: rtl/conv_pool_pkg.sv
// Shared types and constants for conv_pool_engine: FSM states, memory selects,
// 3x3 tap geometry and the default kernel/bias.
package conv_pool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_C_RD,
    S_C_ACC,
    S_C_WR,
    S_P_RD,
    S_P_CMP,
    S_P_WR,
    S_DONE
  } state_t;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  // Taps walk the input window in raster order; tap t pairs with weight K[8-t]
  // so the kernel is applied as a true (flipped) convolution.
  localparam int TAP_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  localparam logic [179:0] DEF_KERNEL = {
    20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
    20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19
  };
  localparam logic [19:0] DEF_BIAS = 20'h01310;

endpackage

// File: rtl/conv_mac.sv
// Signed MAC with bias preload, round/truncate, saturation and ReLU.
// Rounding (half up) is enabled by defining CONV_ROUND_EN.
module conv_mac #(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] result
);
  localparam int AW = 2 * DATA_W + 4;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       bias_ext;
  logic signed [AW-1:0]       rnd;
  logic signed [AW-1:0]       shf;

  always_comb begin
    prod     = $signed(pix) * $signed(weight);
    bias_ext = AW'($signed(bias)) <<< FRAC_W;
  end

  // Clearing preloads the bias so the result is ready right after the last tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   acc <= '0;
    else if (clear) acc <= bias_ext;
    else if (en)    acc <= acc + AW'(prod);
  end

  always_comb begin
`ifdef CONV_ROUND_EN
    rnd = acc + (AW'(1) <<< (FRAC_W - 1));
`else
    rnd = acc;
`endif
    shf = rnd >>> FRAC_W;
    if (shf[AW-1])                 result = '0;
    else if (|shf[AW-2:DATA_W-1])  result = {1'b0, {(DATA_W-1){1'b1}}};
    else                           result = shf[DATA_W-1:0];
  end

endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 convolution (zero pad, bias, ReLU) into layer 0, then 2x2/2 max pooling
// into layer 1. CONV_ROUND_EN selects round-half-up instead of truncation.
module conv_pool_engine
  import conv_pool_pkg::*;
#(
  parameter int                 IMG_W  = 64,
  parameter int                 DATA_W = 20,
  parameter int                 FRAC_W = 16,
  parameter logic [9*DATA_W-1:0] KERNEL = DEF_KERNEL,
  parameter logic [DATA_W-1:0]  BIAS   = DEF_BIAS,
  parameter int                 ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);
  localparam int CW   = $clog2(IMG_W);
  localparam int HALF = IMG_W / 2;

  state_t            state, nxt;
  logic [CW-1:0]     row, col;
  logic [3:0]        tap;
  logic              last_px_c, last_px_p;
  int                ty, tx;
  logic              tap_in;
  logic              c_vld_q, p_vld_q, p_first_q;
  logic [3:0]        w_idx_q;
  logic [DATA_W-1:0] weight, mac_res, max_q;

  assign last_px_c = (row == CW'(IMG_W - 1)) && (col == CW'(IMG_W - 1));
  assign last_px_p = (row == CW'(HALF - 1)) && (col == CW'(HALF - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (ready) nxt = S_C_RD;
      S_C_RD:  if (tap == 4'd8) nxt = S_C_ACC;
      S_C_ACC: nxt = S_C_WR;
      S_C_WR:  nxt = last_px_c ? S_P_RD : S_C_RD;
      S_P_RD:  if (tap == 4'd3) nxt = S_P_CMP;
      S_P_CMP: nxt = S_P_WR;
      S_P_WR:  nxt = last_px_p ? S_DONE : S_P_RD;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
      tap <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row <= '0;
          col <= '0;
          tap <= '0;
        end
        S_C_RD, S_P_RD: begin
          if ((state == S_C_RD && tap == 4'd8) || (state == S_P_RD && tap == 4'd3)) tap <= '0;
          else tap <= tap + 4'd1;
        end
        S_C_WR: begin
          if (last_px_c) begin
            row <= '0;
            col <= '0;
          end else begin
            col <= col + 1'b1;
            if (col == CW'(IMG_W - 1)) row <= row + 1'b1;
          end
        end
        S_P_WR: begin
          if (last_px_p) begin
            row <= '0;
            col <= '0;
          end else if (col == CW'(HALF - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ty     = int'(row) + TAP_DY[tap];
    tx     = int'(col) + TAP_DX[tap];
    tap_in = (ty >= 0) && (ty < IMG_W) && (tx >= 0) && (tx < IMG_W);
  end

  // Read data returns one cycle after the address, so tap validity and weight
  // index are delayed to line up with idata / cdata_rd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_vld_q   <= 1'b0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      w_idx_q   <= '0;
      max_q     <= '0;
    end else begin
      c_vld_q   <= (state == S_C_RD) && tap_in;
      p_vld_q   <= (state == S_P_RD);
      p_first_q <= (state == S_P_RD) && (tap == 4'd0);
      w_idx_q   <= 4'd8 - tap;
      if (p_vld_q && (p_first_q || ($signed(cdata_rd) > $signed(max_q)))) max_q <= cdata_rd;
    end
  end

  assign weight = KERNEL[int'(w_idx_q)*DATA_W +: DATA_W];

  conv_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  ((state == S_IDLE) || (state == S_C_WR)),
    .en     (c_vld_q),
    .bias   (BIAS),
    .pix    (idata),
    .weight (weight),
    .result (mac_res)
  );

  always_comb begin
    busy     = (state != S_IDLE) && (state != S_DONE);
    iaddr    = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = CSEL_NONE;
    case (state)
      S_C_RD: begin
        csel  = CSEL_L0;
        iaddr = tap_in ? ADDR_W'(ty * IMG_W + tx) : '0;
      end
      S_C_ACC: csel = CSEL_L0;
      S_C_WR: begin
        csel     = CSEL_L0;
        cwr      = 1'b1;
        caddr_wr = ADDR_W'(int'(row) * IMG_W + int'(col));
        cdata_wr = mac_res;
      end
      S_P_RD: begin
        csel     = CSEL_L0;
        crd      = 1'b1;
        caddr_rd = ADDR_W'((2 * int'(row) + int'(tap[1])) * IMG_W + 2 * int'(col) + int'(tap[0]));
      end
      S_P_CMP: csel = CSEL_L0;
      S_P_WR: begin
        csel     = CSEL_L1;
        cwr      = 1'b1;
        caddr_wr = ADDR_W'(int'(row) * HALF + int'(col));
        cdata_wr = max_q;
      end
      default: ;
    endcase
  end

endmodule
